// File: rtl/tick_sched_pkg.sv
// Shared types and defaults for the tick scheduler.
package tick_sched_pkg;
    localparam int CNT_W_DEF = 12;
    localparam int DIV_W_DEF = 8;
    localparam int DIV_MIN   = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;
endpackage

// File: rtl/tick_sched_if.sv
// Control/status bundle between the test logic (master) and the tick scheduler (slave).
interface tick_sched_if import tick_sched_pkg::*; #(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DIV_W = DIV_W_DEF
);
    logic             start;
    logic             stop;
    logic             hold;
    logic [DIV_W-1:0] div;
    logic [CNT_W-1:0] burst_len;
    logic             tick;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [CNT_W-1:0] tick_count;

    modport master (
        output start, stop, hold, div, burst_len,
        input  tick, busy, done, aborted, tick_count
    );

    modport slave (
        input  start, stop, hold, div, burst_len,
        output tick, busy, done, aborted, tick_count
    );
endinterface

// File: rtl/tick_sched_divider.sv
// tick_divider: modulo-div_i cycle counter; wrap_o is combinational, high on the last count.
// Latency: wrap_o asserts while the count sits at div_i-1; hold_i freezes the count (no backpressure otherwise).
module tick_divider #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic             hold_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             wrap_o
);
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             at_top;

    assign at_top = (cnt_q == (div_i - DIV_W'(1)));
    assign wrap_o = en_i & ~hold_i & at_top;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && !hold_i) begin
            cnt_d = at_top ? '0 : cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/tick_sched.sv
// tick_sched: clock-enable scheduler issuing one-cycle ticks every div cycles, burst or free-running.
// Latency: first tick div cycles after start, done one cycle after the last tick; hold pauses, stop aborts.
module tick_sched import tick_sched_pkg::*; #(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic         clk,
    input  logic         reset_n,
    tick_sched_if.slave  bus
);
    state_t           state_q;
    logic [DIV_W-1:0] div_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] cnt_q;
    logic             tick_q;
    logic             busy_q;
    logic             done_q;
    logic             aborted_q;
    logic             wrap;
    logic             burst_end;

    tick_divider #(.DIV_W(DIV_W)) u_div (
        .clk     (clk),
        .reset_n (reset_n),
        .clear_i (state_q == IDLE),
        .en_i    (state_q == RUN),
        .hold_i  (bus.hold),
        .div_i   (div_q),
        .wrap_o  (wrap)
    );

    // The cycle showing the final tick ends the burst; no further wrap may tick.
    assign burst_end = (len_q != '0) && (cnt_q == len_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            div_q     <= DIV_W'(DIV_MIN);
            len_q     <= '0;
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        div_q   <= (bus.div == '0) ? DIV_W'(DIV_MIN) : bus.div;
                        len_q   <= bus.burst_len;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state_q   <= FIN;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        aborted_q <= 1'b1;
                    end else if (burst_end) begin
                        state_q <= FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (wrap) begin
                        tick_q <= 1'b1;
                        cnt_q  <= cnt_q + CNT_W'(1);
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tick       = tick_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.aborted    = aborted_q;
    assign bus.tick_count = cnt_q;
endmodule
